// File: rtl/pipe_ctrl.sv
// pipe_ctrl
// Hazard and interrupt-entry controller for a five-stage in-order pipeline.
// Resolves, in priority order: reset, data-memory stall (whole pipe freezes),
// taken branch (flush IF/ID and ID/EX), interrupt entry, and load-use stall.
// Interrupt entry drains the pipe for three cycles, pushes PC then flags,
// and finally selects the vector while acknowledging the interrupt.
//
// Ports
//   clk                        rising-edge clock
//   rst                        synchronous active-high reset
//   id_src1, id_src2           ID-stage source register numbers
//   id_use_src1, id_use_src2   the matching source field is really read
//   ex_mem_read, ex_dest       EX-stage load flag and its destination register
//   branch_taken               branch/jump resolved taken in EX this cycle
//   mem_stall                  data memory busy, freeze everything
//   int_req                    external interrupt request (pulse or level)
//   pc_write_en, ifid_write_en, exmem_write_en   pipeline register enables
//   ifid_flush, idex_flush     bubble insertion into IF/ID and ID/EX
//   push_pc, push_flags        interrupt context-save strobes
//   pc_sel_vector, int_ack     vector select and interrupt acknowledge
//   state                      current controller state (debug)
module pipe_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] id_src1,
  input  logic [2:0] id_src2,
  input  logic       id_use_src1,
  input  logic       id_use_src2,
  input  logic       ex_mem_read,
  input  logic [2:0] ex_dest,
  input  logic       branch_taken,
  input  logic       mem_stall,
  input  logic       int_req,
  output logic       pc_write_en,
  output logic       ifid_write_en,
  output logic       exmem_write_en,
  output logic       ifid_flush,
  output logic       idex_flush,
  output logic       push_pc,
  output logic       push_flags,
  output logic       pc_sel_vector,
  output logic       int_ack,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    ST_RUN        = 3'd0,
    ST_DRAIN      = 3'd1,
    ST_PUSH_PC    = 3'd2,
    ST_PUSH_FLAGS = 3'd3,
    ST_VECTOR     = 3'd4
  } state_e;

  state_e     state_r;
  state_e     state_nxt_s;
  logic       pending_r;
  logic       pending_nxt_s;
  logic [1:0] cnt_r;
  logic [1:0] cnt_nxt_s;
  logic       load_use_s;

  // Load-use hazard: EX holds a load whose destination an ID operand really reads.
  always_comb begin
    load_use_s = ex_mem_read &
                 ((id_use_src1 & (id_src1 == ex_dest)) |
                  (id_use_src2 & (id_src2 == ex_dest)));
  end

  // Output decode and next-state logic for the hazard/interrupt sequencer.
  always_comb begin
    pc_write_en    = 1'b1;
    ifid_write_en  = 1'b1;
    exmem_write_en = 1'b1;
    ifid_flush     = 1'b0;
    idex_flush     = 1'b0;
    push_pc        = 1'b0;
    push_flags     = 1'b0;
    pc_sel_vector  = 1'b0;
    int_ack        = 1'b0;
    state_nxt_s    = state_r;
    cnt_nxt_s      = cnt_r;
    // A request is latched on every cycle, including stalled ones.
    pending_nxt_s  = pending_r | int_req;

    if (rst) begin
      pc_write_en    = 1'b0;
      ifid_write_en  = 1'b0;
      exmem_write_en = 1'b0;
      ifid_flush     = 1'b1;
      idex_flush     = 1'b1;
      state_nxt_s    = ST_RUN;
      cnt_nxt_s      = 2'd0;
      pending_nxt_s  = 1'b0;
    end else if (mem_stall) begin
      // Whole pipeline frozen: no enables, no flushes, no strobes, state held.
      pc_write_en    = 1'b0;
      ifid_write_en  = 1'b0;
      exmem_write_en = 1'b0;
      if (state_r > ST_VECTOR) begin
        state_nxt_s = ST_RUN;
      end else begin
        state_nxt_s = state_r;
      end
    end else begin
      case (state_r)
        ST_RUN: begin
          if (branch_taken) begin
            // Branch wins; an arriving request stays pending for next cycle.
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
          end else if (pending_r | int_req) begin
            pc_write_en   = 1'b0;
            ifid_write_en = 1'b0;
            ifid_flush    = 1'b1;
            idex_flush    = 1'b1;
            cnt_nxt_s     = 2'd2;
            state_nxt_s   = ST_DRAIN;
            // Clearing on entry loses to a request in the same cycle.
            pending_nxt_s = int_req;
          end else if (load_use_s) begin
            pc_write_en   = 1'b0;
            ifid_write_en = 1'b0;
            idex_flush    = 1'b1;
          end else begin
            state_nxt_s = ST_RUN;
          end
        end
        ST_DRAIN: begin
          pc_write_en   = 1'b0;
          ifid_write_en = 1'b0;
          ifid_flush    = 1'b1;
          idex_flush    = 1'b1;
          // cnt counts 2,1,0 so DRAIN lasts three cycles.
          if (cnt_r == 2'd0) begin
            state_nxt_s = ST_PUSH_PC;
          end else begin
            cnt_nxt_s = cnt_r - 2'd1;
          end
        end
        ST_PUSH_PC: begin
          push_pc     = 1'b1;
          pc_write_en = 1'b0;
          ifid_flush  = 1'b1;
          idex_flush  = 1'b1;
          state_nxt_s = ST_PUSH_FLAGS;
        end
        ST_PUSH_FLAGS: begin
          push_flags  = 1'b1;
          pc_write_en = 1'b0;
          ifid_flush  = 1'b1;
          idex_flush  = 1'b1;
          state_nxt_s = ST_VECTOR;
        end
        ST_VECTOR: begin
          pc_sel_vector = 1'b1;
          int_ack       = 1'b1;
          pc_write_en   = 1'b1;
          ifid_flush    = 1'b1;
          idex_flush    = 1'b1;
          state_nxt_s   = ST_RUN;
        end
        default: begin
          state_nxt_s = ST_RUN;
        end
      endcase
    end
  end

  // State, drain counter and pending-interrupt registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_RUN;
      cnt_r     <= 2'd0;
      pending_r <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      cnt_r     <= cnt_nxt_s;
      pending_r <= pending_nxt_s;
    end
  end

  assign state = state_r;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: table vectors for the RUN-state hazards,
// hand-written interrupt sequences, and a randomized run against a model that
// tracks the interrupt sequence as a position 0..6 plus a pending flag.
module tb_pipe_ctrl;

  logic       clk;
  logic       rst;
  logic [2:0] id_src1;
  logic [2:0] id_src2;
  logic       id_use_src1;
  logic       id_use_src2;
  logic       ex_mem_read;
  logic [2:0] ex_dest;
  logic       branch_taken;
  logic       mem_stall;
  logic       int_req;
  logic       pc_write_en;
  logic       ifid_write_en;
  logic       exmem_write_en;
  logic       ifid_flush;
  logic       idex_flush;
  logic       push_pc;
  logic       push_flags;
  logic       pc_sel_vector;
  logic       int_ack;
  logic [2:0] state;

  pipe_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .id_src1        (id_src1),
    .id_src2        (id_src2),
    .id_use_src1    (id_use_src1),
    .id_use_src2    (id_use_src2),
    .ex_mem_read    (ex_mem_read),
    .ex_dest        (ex_dest),
    .branch_taken   (branch_taken),
    .mem_stall      (mem_stall),
    .int_req        (int_req),
    .pc_write_en    (pc_write_en),
    .ifid_write_en  (ifid_write_en),
    .exmem_write_en (exmem_write_en),
    .ifid_flush     (ifid_flush),
    .idex_flush     (idex_flush),
    .push_pc        (push_pc),
    .push_flags     (push_flags),
    .pc_sel_vector  (pc_sel_vector),
    .int_ack        (int_ack),
    .state          (state)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       rst;
    logic       ms;
    logic       br;
    logic       ir;
    logic       emr;
    logic [2:0] ed;
    logic [2:0] s1;
    logic [2:0] s2;
    logic       u1;
    logic       u2;
  } in_t;

  typedef struct packed {
    in_t         vin;
    logic [11:0] exp;
  } vec_t;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [11:0] last_out;

  // Model: m_pos 0 = running, 1..3 = drain, 4 = push pc, 5 = push flags, 6 = vector.
  int m_pos  = 0;
  bit m_pend = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Output bit layout: pc_we ifid_we exmem_we ifid_fl idex_fl push_pc push_flags pc_sel ack state[2:0]
  function automatic logic [11:0] pack_dut();
    return {pc_write_en, ifid_write_en, exmem_write_en, ifid_flush, idex_flush,
            push_pc, push_flags, pc_sel_vector, int_ack, state};
  endfunction

  function automatic logic [2:0] pos_code(input int p);
    case (p)
      0:       return 3'd0;
      1, 2, 3: return 3'd1;
      4:       return 3'd2;
      5:       return 3'd3;
      6:       return 3'd4;
      default: return 3'd7;
    endcase
  endfunction

  function automatic logic [11:0] model_out(input in_t v);
    logic       lu;
    logic [2:0] c;
    c  = pos_code(m_pos);
    lu = v.emr && ((v.u1 && v.s1 == v.ed) || (v.u2 && v.s2 == v.ed));
    if (v.rst)                  return {5'b00011, 4'b0000, c};
    if (v.ms)                   return {5'b00000, 4'b0000, c};
    if (m_pos == 0) begin
      if (v.br)                 return {5'b11111, 4'b0000, c};
      if (m_pend || v.ir)       return {5'b00111, 4'b0000, c};
      if (lu)                   return {5'b00101, 4'b0000, c};
      return {5'b11100, 4'b0000, c};
    end
    if (m_pos <= 3)             return {5'b00111, 4'b0000, c};
    if (m_pos == 4)             return {5'b01111, 4'b1000, c};
    if (m_pos == 5)             return {5'b01111, 4'b0100, c};
    return {5'b11111, 4'b0011, c};
  endfunction

  task automatic model_step(input in_t v);
    if (v.rst) begin
      m_pos  = 0;
      m_pend = 1'b0;
    end else if (v.ms) begin
      m_pend = m_pend | v.ir;
    end else if (m_pos == 0) begin
      if (!v.br && (m_pend || v.ir)) begin
        m_pos  = 1;
        m_pend = v.ir;
      end else begin
        m_pend = m_pend | v.ir;
      end
    end else begin
      m_pos  = (m_pos == 6) ? 0 : m_pos + 1;
      m_pend = m_pend | v.ir;
    end
  endtask

  // One clock cycle: drive after the edge, sample on the falling edge, check vs model.
  task automatic cycle(input in_t v);
    logic [11:0] e;
    rst          = v.rst;
    mem_stall    = v.ms;
    branch_taken = v.br;
    int_req      = v.ir;
    ex_mem_read  = v.emr;
    ex_dest      = v.ed;
    id_src1      = v.s1;
    id_src2      = v.s2;
    id_use_src1  = v.u1;
    id_use_src2  = v.u2;
    @(negedge clk);
    last_out = pack_dut();
    e = model_out(v);
    check("model", {20'd0, last_out}, {20'd0, e});
    model_step(v);
    @(posedge clk);
    #1;
  endtask

  function automatic in_t mk(input logic br, input logic emr, input logic [2:0] ed,
                             input logic [2:0] s1, input logic u1,
                             input logic [2:0] s2, input logic u2);
    in_t v;
    v     = '0;
    v.br  = br;
    v.emr = emr;
    v.ed  = ed;
    v.s1  = s1;
    v.u1  = u1;
    v.s2  = s2;
    v.u2  = u2;
    return v;
  endfunction

  task automatic drain_to_idle();
    in_t z;
    z = '0;
    for (int k = 0; k < 24; k++) begin
      if (m_pos != 0 || m_pend) cycle(z);
    end
    check("drain_idle", {31'd0, (m_pos != 0 || m_pend)}, 32'd0);
  endtask

  initial begin
    vec_t tbl[10];
    in_t  v;
    in_t  z;
    int   tr33[8];
    int   tr34[16];
    int   tr35[11];
    int   pp_at, pf_at, ack_at, pp_n, pf_n, ack_n;

    z = '0;
    tbl[0] = '{mk(1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0), 12'hE00};
    tbl[1] = '{mk(1'b0, 1'b1, 3'd3, 3'd5, 1'b1, 3'd3, 1'b1), 12'h280};
    tbl[2] = '{mk(1'b0, 1'b1, 3'd3, 3'd5, 1'b1, 3'd3, 1'b0), 12'hE00};
    tbl[3] = '{mk(1'b0, 1'b1, 3'd6, 3'd6, 1'b1, 3'd0, 1'b0), 12'h280};
    tbl[4] = '{mk(1'b0, 1'b1, 3'd2, 3'd2, 1'b0, 3'd2, 1'b1), 12'h280};
    tbl[5] = '{mk(1'b0, 1'b0, 3'd4, 3'd4, 1'b1, 3'd4, 1'b1), 12'hE00};
    tbl[6] = '{mk(1'b1, 1'b1, 3'd3, 3'd1, 1'b1, 3'd3, 1'b1), 12'hF80};
    tbl[7] = '{mk(1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0), 12'hF80};
    tbl[8] = '{mk(1'b0, 1'b1, 3'd0, 3'd0, 1'b1, 3'd1, 1'b1), 12'h280};
    tbl[9] = '{mk(1'b0, 1'b1, 3'd7, 3'd6, 1'b1, 3'd7, 1'b1), 12'h280};

    // Initial reset edge so the DUT registers are defined.
    rst = 1'b1; mem_stall = 1'b0; branch_taken = 1'b0; int_req = 1'b0;
    ex_mem_read = 1'b0; ex_dest = 3'd0; id_src1 = 3'd0; id_src2 = 3'd0;
    id_use_src1 = 1'b0; id_use_src2 = 1'b0;
    @(posedge clk);
    #1;

    // Outputs while reset is held.
    v = '0; v.rst = 1'b1; v.ir = 1'b1;
    cycle(v);
    check("reset_outputs", {20'd0, last_out}, {20'd0, 12'h180});

    // RUN-state vectors; the first one is the first cycle after reset release.
    for (int i = 0; i < 10; i++) begin
      cycle(tbl[i].vin);
      check($sformatf("vec%0d", i), {20'd0, last_out}, {20'd0, tbl[i].exp});
    end

    // Single-cycle request from RUN: full entry sequence.
    tr33 = '{0, 1, 1, 1, 2, 3, 4, 0};
    pp_at = -1; pf_at = -1; ack_at = -1; pp_n = 0; pf_n = 0; ack_n = 0;
    for (int i = 0; i < 8; i++) begin
      v = '0; v.ir = (i == 0);
      cycle(v);
      check($sformatf("seq33_state%0d", i), {29'd0, last_out[2:0]}, tr33[i]);
      if (last_out[6]) begin pp_n++;  pp_at  = i; end
      if (last_out[5]) begin pf_n++;  pf_at  = i; end
      if (last_out[3]) begin ack_n++; ack_at = i; end
    end
    check("seq33_counts", {8'd0, pp_n[7:0], pf_n[7:0], ack_n[7:0]}, {8'd0, 8'd1, 8'd1, 8'd1});
    check("seq33_order", {29'd0, pp_at[2:0]} + {pf_at[2:0], 3'd0} + {ack_at[2:0], 6'd0},
          32'd4 + (32'd5 << 3) + (32'd6 << 6));
    drain_to_idle();

    // Request with branch, then a second request during PUSH_PC.
    tr34 = '{0, 0, 1, 1, 1, 2, 3, 4, 0, 1, 1, 1, 2, 3, 4, 0};
    for (int i = 0; i < 16; i++) begin
      v = '0;
      v.br = (i == 0);
      v.ir = (i == 0) || (i == 5);
      cycle(v);
      check($sformatf("seq34_state%0d", i), {29'd0, last_out[2:0]}, tr34[i]);
      if (i == 0) check("seq34_branch", {23'd0, last_out[11:3]}, {23'd0, 9'b111110000});
      if (i == 1) check("seq34_entry", {23'd0, last_out[11:3]}, {23'd0, 9'b001110000});
    end
    drain_to_idle();

    // Memory stall for four cycles while DRAIN has two cycles left.
    tr35 = '{0, 1, 1, 1, 1, 1, 1, 1, 2, 3, 4};
    for (int i = 0; i < 11; i++) begin
      v = '0;
      v.ir = (i == 0);
      v.ms = (i >= 2 && i <= 5);
      v.br = (i == 3);
      cycle(v);
      check($sformatf("seq35_state%0d", i), {29'd0, last_out[2:0]}, tr35[i]);
      if (v.ms) check($sformatf("seq35_frozen%0d", i), {23'd0, last_out[11:3]}, 32'd0);
    end
    drain_to_idle();

    // Reset during PUSH_FLAGS with a request pending: no ack, no re-entry.
    for (int i = 0; i < 6; i++) begin
      v = '0;
      v.ir  = (i == 0) || (i == 2);
      v.rst = (i == 5);
      cycle(v);
    end
    check("rst36_outputs", {20'd0, last_out}, {20'd0, 12'h183});
    for (int i = 0; i < 8; i++) begin
      cycle(z);
      check($sformatf("rst36_idle%0d", i), {20'd0, last_out}, {20'd0, 12'hE00});
    end

    // Randomized run against the model.
    for (int i = 0; i < 3000; i++) begin
      v     = '0;
      v.rst = ($urandom_range(0, 63) == 0);
      v.ms  = ($urandom_range(0, 5) == 0);
      v.br  = ($urandom_range(0, 4) == 0);
      v.ir  = ($urandom_range(0, 11) == 0);
      v.emr = $urandom_range(0, 1);
      v.ed  = 3'($urandom_range(0, 7));
      v.s1  = 3'($urandom_range(0, 7));
      v.s2  = ($urandom_range(0, 1) == 1) ? v.ed : 3'($urandom_range(0, 7));
      v.u1  = $urandom_range(0, 1);
      v.u2  = $urandom_range(0, 1);
      cycle(v);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
